// File: rtl/mem_access_unit.sv
// mem_access_unit: 24-bit sesqui-word load/store engine over an internal
// byte-wide RAM. Each request is served as three big-endian byte accesses
// (IDLE -> B0 -> B1 -> B2 -> DONE -> IDLE) with fixed latency.
module mem_access_unit #(
   parameter int ADDR_W    = 8,
   parameter int MEM_BYTES = 256
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              MemRead,
   input  logic              MemWrite,
   input  logic [ADDR_W-1:0] Address,
   input  logic [23:0]       WriteData,
   output logic [23:0]       ReadData,
   output logic              Busy,
   output logic              Done,
   output logic              ReqErr
);

   typedef enum logic [2:0] {IDLE, B0, B1, B2, DONE} state_t;

   state_t            state_reg;
   logic              op_write_reg;
   logic [ADDR_W-1:0] addr_reg;
   logic [23:0]       wdata_reg;
   logic [15:0]       asm_reg;
   logic [23:0]       read_data_reg;
   logic              busy_reg;
   logic              done_reg;
   logic              req_err_reg;

   // Byte RAM; never cleared, so contents survive reset.
   logic [7:0]        mem [MEM_BYTES];

   logic [1:0]        byte_sel;
   logic [ADDR_W-1:0] byte_addr;
   logic [7:0]        wr_byte;
   logic [7:0]        rd_byte;
   logic              ram_we;

   // Select which byte of the sesqui-word the current state touches; the
   // address adder truncates to ADDR_W bits so accesses wrap around the RAM.
   always_comb begin
      byte_sel = 2'd0;
      wr_byte  = wdata_reg[23:16];
      ram_we   = 1'b0;
      case (state_reg)
         B0: begin
            byte_sel = 2'd0;
            wr_byte  = wdata_reg[23:16];
            ram_we   = op_write_reg;
         end
         B1: begin
            byte_sel = 2'd1;
            wr_byte  = wdata_reg[15:8];
            ram_we   = op_write_reg;
         end
         B2: begin
            byte_sel = 2'd2;
            wr_byte  = wdata_reg[7:0];
            ram_we   = op_write_reg;
         end
         default: begin
            byte_sel = 2'd0;
            wr_byte  = wdata_reg[23:16];
            ram_we   = 1'b0;
         end
      endcase
      // A reset edge aborts a store before the byte of the current state lands.
      if (reset) begin
         ram_we = 1'b0;
      end
   end

   assign byte_addr = addr_reg + ADDR_W'(byte_sel);
   assign rd_byte   = mem[byte_addr];

   // RAM write port: one byte per B-state of a store.
   always_ff @(posedge clk) begin
      if (ram_we) begin
         mem[byte_addr] <= wr_byte;
      end
   end

   // Control FSM with registered status outputs and load assembly.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg     <= IDLE;
         busy_reg      <= 1'b0;
         done_reg      <= 1'b0;
         req_err_reg   <= 1'b0;
         read_data_reg <= 24'h000000;
         op_write_reg  <= 1'b0;
         addr_reg      <= '0;
         wdata_reg     <= 24'h000000;
         asm_reg       <= 16'h0000;
      end else begin
         done_reg    <= 1'b0;
         req_err_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (MemRead ^ MemWrite) begin
                  addr_reg     <= Address;
                  wdata_reg    <= WriteData;
                  op_write_reg <= MemWrite;
                  busy_reg     <= 1'b1;
                  state_reg    <= B0;
               end else if (MemRead && MemWrite) begin
                  req_err_reg <= 1'b1;
               end
            end
            B0: begin
               if (!op_write_reg) begin
                  asm_reg[15:8] <= rd_byte;
               end
               state_reg <= B1;
            end
            B1: begin
               if (!op_write_reg) begin
                  asm_reg[7:0] <= rd_byte;
               end
               state_reg <= B2;
            end
            B2: begin
               // Only a completed load publishes a new ReadData value.
               if (!op_write_reg) begin
                  read_data_reg <= {asm_reg, rd_byte};
               end
               done_reg  <= 1'b1;
               state_reg <= DONE;
            end
            DONE: begin
               busy_reg  <= 1'b0;
               state_reg <= IDLE;
            end
            default: begin
               busy_reg  <= 1'b0;
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign ReadData = read_data_reg;
   assign Busy     = busy_reg;
   assign Done     = done_reg;
   assign ReqErr   = req_err_reg;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a table of load/store/error vectors
// plus hand-written sequences for busy-time requests and reset aborts.
module tb_mem_access_unit;

   logic        clk;
   logic        reset;
   logic        MemRead;
   logic        MemWrite;
   logic [7:0]  Address;
   logic [23:0] WriteData;
   logic [23:0] ReadData;
   logic        Busy;
   logic        Done;
   logic        ReqErr;

   int checks = 0;
   int errors = 0;

   mem_access_unit #(.ADDR_W(8), .MEM_BYTES(256)) dut (
      .clk       (clk),
      .reset     (reset),
      .MemRead   (MemRead),
      .MemWrite  (MemWrite),
      .Address   (Address),
      .WriteData (WriteData),
      .ReadData  (ReadData),
      .Busy      (Busy),
      .Done      (Done),
      .ReqErr    (ReqErr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rd;
      logic        wr;
      logic [7:0]  addr;
      logic [23:0] wdata;
      logic [23:0] exp_rdata;
   } vec_t;

   vec_t vecs [13];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Present a request for exactly one rising edge; returns at the first
   // falling edge after that edge (the FSM is then in B0 for a valid request).
   task automatic issue(input logic rd, input logic wr, input logic [7:0] a, input logic [23:0] d);
      @(negedge clk);
      MemRead   = rd;
      MemWrite  = wr;
      Address   = a;
      WriteData = d;
      @(negedge clk);
      MemRead  = 1'b0;
      MemWrite = 1'b0;
   endtask

   // Count falling edges since the accepting edge until Done is seen.
   task automatic wait_done(output int lat);
      lat = 1;
      while (!Done && lat < 20) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic count_dones(input int cycles, output int n);
      n = 0;
      for (int c = 0; c < cycles; c++) begin
         @(negedge clk);
         if (Done) n++;
      end
   endtask

   // Full request with latency and result checks.
   task automatic xfer(input string name, input logic rd, input logic [7:0] a,
                       input logic [23:0] d, input logic [23:0] exp_rdata);
      int lat;
      issue(rd, !rd, a, d);
      check({name, "_busy"}, {31'd0, Busy}, 32'd1);
      wait_done(lat);
      check({name, "_latency"}, lat, 4);
      check({name, "_rdata"}, {8'd0, ReadData}, {8'd0, exp_rdata});
      @(negedge clk);
      check({name, "_idle"}, {31'd0, Busy}, 32'd0);
      $display("%s rd=%0b addr=%h wdata=%h ReadData=%h latency=%0d", name, rd, a, d, ReadData, lat);
   endtask

   initial begin
      int lat;
      int n;

      vecs[0]  = '{1'b0, 1'b1, 8'h10, 24'hABCDEF, 24'h000000};
      vecs[1]  = '{1'b1, 1'b0, 8'h10, 24'h000000, 24'hABCDEF};
      vecs[2]  = '{1'b0, 1'b1, 8'hFF, 24'h123456, 24'hABCDEF};
      vecs[3]  = '{1'b1, 1'b0, 8'hFF, 24'h000000, 24'h123456};
      vecs[4]  = '{1'b0, 1'b1, 8'h13, 24'h112233, 24'h123456};
      vecs[5]  = '{1'b1, 1'b0, 8'h11, 24'h000000, 24'hCDEF11};
      vecs[6]  = '{1'b0, 1'b1, 8'h02, 24'hAABBCC, 24'hCDEF11};
      vecs[7]  = '{1'b1, 1'b0, 8'h00, 24'h000000, 24'h3456AA};
      vecs[8]  = '{1'b0, 1'b1, 8'hFC, 24'h010203, 24'h3456AA};
      vecs[9]  = '{1'b1, 1'b0, 8'hFE, 24'h000000, 24'h031234};
      vecs[10] = '{1'b1, 1'b1, 8'h10, 24'h999999, 24'h031234};
      vecs[11] = '{1'b1, 1'b0, 8'h10, 24'h000000, 24'hABCDEF};
      vecs[12] = '{1'b1, 1'b0, 8'h12, 24'h000000, 24'hEF1122};

      reset     = 1'b1;
      MemRead   = 1'b0;
      MemWrite  = 1'b0;
      Address   = 8'h00;
      WriteData = 24'h000000;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      check("reset_rdata", {8'd0, ReadData}, 32'd0);
      check("reset_busy", {31'd0, Busy}, 32'd0);
      check("reset_done", {31'd0, Done}, 32'd0);
      check("reset_reqerr", {31'd0, ReqErr}, 32'd0);
      $display("reset ReadData=%h Busy=%0b Done=%0b ReqErr=%0b", ReadData, Busy, Done, ReqErr);

      // Table-driven loads, stores and illegal requests.
      for (int i = 0; i < 13; i++) begin
         if (vecs[i].rd && vecs[i].wr) begin
            issue(1'b1, 1'b1, vecs[i].addr, vecs[i].wdata);
            check($sformatf("vec%0d_reqerr", i), {31'd0, ReqErr}, 32'd1);
            check($sformatf("vec%0d_busy", i), {31'd0, Busy}, 32'd0);
            check($sformatf("vec%0d_rdata", i), {8'd0, ReadData}, {8'd0, vecs[i].exp_rdata});
            @(negedge clk);
            check($sformatf("vec%0d_reqerr_end", i), {31'd0, ReqErr}, 32'd0);
            check($sformatf("vec%0d_busy_end", i), {31'd0, Busy}, 32'd0);
            $display("vec %0d illegal addr=%h ReadData=%h", i, vecs[i].addr, ReadData);
         end else begin
            xfer($sformatf("vec%0d", i), vecs[i].rd, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata);
         end
      end

      // Load then store with a spurious read pulse while busy: ReadData must
      // hold the loaded word and the store must finish with a single Done.
      xfer("pre_load", 1'b1, 8'h10, 24'h000000, 24'hABCDEF);
      issue(1'b0, 1'b1, 8'h40, 24'h445566);
      check("busy_store_busy", {31'd0, Busy}, 32'd1);
      MemRead = 1'b1;
      Address = 8'h10;
      @(negedge clk);
      MemRead = 1'b0;
      check("busy_store_rdata_b1", {8'd0, ReadData}, 32'h00ABCDEF);
      lat = 2;
      while (!Done && lat < 20) begin
         @(negedge clk);
         lat++;
         check("busy_store_rdata_hold", {8'd0, ReadData}, 32'h00ABCDEF);
      end
      check("busy_store_latency", lat, 4);
      count_dones(8, n);
      check("busy_store_extra_done", n, 0);
      check("busy_store_rdata_after", {8'd0, ReadData}, 32'h00ABCDEF);
      $display("busy_store addr=40 latency=%0d extra_dones=%0d ReadData=%h", lat, n, ReadData);
      xfer("busy_store_verify", 1'b1, 8'h40, 24'h000000, 24'h445566);

      // Reset in B1 of a store: only the first byte lands.
      xfer("clear20", 1'b0, 8'h20, 24'h000000, 24'h445566);
      issue(1'b0, 1'b1, 8'h20, 24'h778899);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("abort_store_busy", {31'd0, Busy}, 32'd0);
      check("abort_store_done", {31'd0, Done}, 32'd0);
      check("abort_store_rdata", {8'd0, ReadData}, 32'd0);
      $display("abort_store addr=20 Busy=%0b Done=%0b ReadData=%h", Busy, Done, ReadData);
      xfer("abort_store_verify", 1'b1, 8'h20, 24'h000000, 24'h770000);

      // Reset in B1 of a load: no Done and ReadData cleared.
      issue(1'b1, 1'b0, 8'h10, 24'h000000);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      count_dones(6, n);
      check("abort_load_done", n, 0);
      check("abort_load_rdata", {8'd0, ReadData}, 32'd0);
      check("abort_load_busy", {31'd0, Busy}, 32'd0);
      $display("abort_load addr=10 dones=%0d ReadData=%h", n, ReadData);

      // Reset wins over a request presented at the same edge.
      @(negedge clk);
      reset   = 1'b1;
      MemRead = 1'b1;
      Address = 8'h10;
      @(negedge clk);
      reset   = 1'b0;
      MemRead = 1'b0;
      check("reset_prio_busy", {31'd0, Busy}, 32'd0);
      count_dones(6, n);
      check("reset_prio_done", n, 0);
      $display("reset_priority Busy=%0b dones=%0d", Busy, n);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
